// File: rtl/uart_rx_seq_pkg.sv
// rtl/uart_rx_seq_pkg.sv - shared types and constants for the UART receive sequencer
package uart_rx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int ENTRY_W     = $bits(rx_entry_t);

  localparam int IRQ_THR_BIT = 0;
  localparam int IRQ_TMO_BIT = 1;
  localparam int IRQ_OVR_BIT = 2;

endpackage

// File: rtl/uart_rx_seq_fifo.sv
// rtl/uart_rx_seq_fifo.sv - synchronous FIFO holding received bytes and their error tags
module uart_rx_seq_fifo
  import uart_rx_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [LW-1:0]      level_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               pop_ok;
  logic               push_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  // An empty FIFO presents zeros rather than stale storage contents.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pop only when data exists; a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are masked at the head while empty, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - captures receiver bytes into a FIFO, re-arms the receiver, raises status and IRQ
module uart_rx_sequencer
  import uart_rx_seq_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int THRESHOLD     = 2,
  parameter int TIMEOUT_TICKS = 640,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          baud_tick_i,
  input  logic          rx_rdy_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_parity_err_i,
  input  logic          rx_framing_err_i,
  input  logic          rx_overflow_i,
  output logic          rx_read_o,
  output logic          rx_clr_parity_o,
  output logic          rx_clr_framing_o,
  input  logic          host_rd_i,
  output logic [7:0]    host_data_o,
  output logic          host_perr_o,
  output logic          host_ferr_o,
  output logic          host_valid_o,
  output logic [LW-1:0] host_level_o,
  input  logic          host_clr_ovr_i,
  output logic          rx_ovr_o,
  output logic          fifo_ovr_o,
  output logic          timeout_o,
  input  logic [2:0]    irq_en_i,
  output logic          irq_o
);

  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_TICKS);

  state_e        state_q, state_d;
  logic          rx_read_q, rx_read_d;
  logic          clr_par_q, clr_par_d;
  logic          clr_frm_q, clr_frm_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          fifo_ovr_q, fifo_ovr_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic          irq_q, irq_d;

  logic          push;
  logic          drop;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  rx_entry_t     wr_entry;
  rx_entry_t     head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [2:0]    irq_src;

  assign wr_entry   = '{perr: rx_parity_err_i, ferr: rx_framing_err_i, data: rx_data_i};
  assign head_entry = rx_entry_t'(head_bits);
  assign pop        = host_rd_i & ~fifo_empty;

  uart_rx_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (host_rd_i),
    .head_o  (head_bits),
    .level_o (host_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Capture FSM: take one byte in IDLE, strobe the receiver in ACK, wait for RX_RDY to drop.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    drop      = 1'b0;
    rx_read_d = 1'b0;
    clr_par_d = 1'b0;
    clr_frm_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_rdy_i) begin
          rx_read_d = 1'b1;
          clr_par_d = rx_parity_err_i;
          clr_frm_d = rx_framing_err_i;
          state_d   = ST_ACK;
          if (fifo_full && !pop) begin
            drop = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!rx_rdy_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags, idle-line timeout counter and interrupt combination.
  always_comb begin
    rx_ovr_d   = rx_ovr_q;
    fifo_ovr_d = fifo_ovr_q;
    if (host_clr_ovr_i) begin
      rx_ovr_d   = 1'b0;
      fifo_ovr_d = 1'b0;
    end
    if (rx_overflow_i) begin
      rx_ovr_d = 1'b1;
    end
    if (drop) begin
      fifo_ovr_d = 1'b1;
    end

    tmo_cnt_d = tmo_cnt_q;
    if (push || pop || fifo_empty) begin
      tmo_cnt_d = '0;
    end else if (baud_tick_i && tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    timeout_d = timeout_q;
    if (pop || fifo_empty) begin
      timeout_d = 1'b0;
    end else if (tmo_cnt_q == TMO_MAX) begin
      timeout_d = 1'b1;
    end

    irq_src[IRQ_THR_BIT] = (host_level_o >= LW'(THRESHOLD));
    irq_src[IRQ_TMO_BIT] = timeout_q;
    irq_src[IRQ_OVR_BIT] = rx_ovr_q | fifo_ovr_q;
    irq_d = |(irq_src & irq_en_i);
  end

  // State, strobe and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rx_read_q  <= 1'b0;
      clr_par_q  <= 1'b0;
      clr_frm_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      fifo_ovr_q <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_read_q  <= rx_read_d;
      clr_par_q  <= clr_par_d;
      clr_frm_q  <= clr_frm_d;
      rx_ovr_q   <= rx_ovr_d;
      fifo_ovr_q <= fifo_ovr_d;
      timeout_q  <= timeout_d;
      tmo_cnt_q  <= tmo_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_read_o        = rx_read_q;
  assign rx_clr_parity_o  = clr_par_q;
  assign rx_clr_framing_o = clr_frm_q;
  assign host_data_o      = head_entry.data;
  assign host_perr_o      = head_entry.perr;
  assign host_ferr_o      = head_entry.ferr;
  assign host_valid_o     = ~fifo_empty;
  assign rx_ovr_o         = rx_ovr_q;
  assign fifo_ovr_o       = fifo_ovr_q;
  assign timeout_o        = timeout_q;
  assign irq_o            = irq_q;

endmodule
